// File: rtl/dspb_serum_qsys_nios2_qsys_0_oci_dct_ctrl.sv
// Nios II OCI data-capture-trace buffer sequencer.
// Packs 2-bit atoms into a 30-bit word and hands words to the trace sink.
module dspb_serum_qsys_nios2_qsys_0_oci_dct_ctrl #(
    parameter int unsigned IDLE_FLUSH_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        atom_valid,
    input  logic [1:0]  atom_data,
    output logic        atom_ready,
    input  logic        flush_req,
    input  logic        test_ending,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        test_has_ended
);

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        ENDED
    } state_t;

    localparam logic [7:0] IDLE_MAX = 8'(IDLE_FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [29:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  idle_q, idle_d;
    logic        end_q, end_d;
    logic        accept;
    logic        have;

    assign accept         = atom_valid && (state_q == FILL);
    assign atom_ready     = (state_q == FILL);
    assign out_valid      = (state_q == EMIT);
    assign test_has_ended = (state_q == ENDED);
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;

    // Next-state, packing, idle timer and end-of-test latching.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        end_d   = end_q;
        have    = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < 15; i++) begin
                        if (cnt_q == 4'(i)) begin
                            buf_d[2*i +: 2] = atom_data;
                        end
                    end
                    cnt_d  = cnt_q + 4'd1;
                    idle_d = 8'd0;
                end else if (cnt_q == 4'd0) begin
                    idle_d = 8'd0;
                end else if (idle_q < IDLE_MAX) begin
                    idle_d = idle_q + 8'd1;
                end
                // The atom taken this cycle counts toward "buffer not empty".
                have = (cnt_d != 4'd0);
                if (test_ending) begin
                    if (have) begin
                        state_d = EMIT;
                        end_d   = 1'b1;
                    end else begin
                        state_d = ENDED;
                    end
                end else if (cnt_d == 4'd15) begin
                    state_d = EMIT;
                end else if (flush_req && have) begin
                    state_d = EMIT;
                end else if (!accept && have && idle_d == IDLE_MAX) begin
                    state_d = EMIT;
                end
                if (state_d != FILL) begin
                    idle_d = 8'd0;
                end
            end
            EMIT: begin
                idle_d = 8'd0;
                if (test_ending) begin
                    end_d = 1'b1;
                end
                if (out_ready) begin
                    buf_d   = 30'd0;
                    cnt_d   = 4'd0;
                    state_d = (end_q || test_ending) ? ENDED : FILL;
                end
            end
            ENDED: begin
                idle_d = 8'd0;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            buf_q   <= 30'd0;
            cnt_q   <= 4'd0;
            idle_q  <= 8'd0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            end_q   <= end_d;
        end
    end

endmodule
